// File: rtl/shift_exec_if.sv
// Operand, shifter-control and result bus of the shift execute stage.
// Valid/ready: a transfer happens on a rising edge where valid & ready are both high;
// valid and its payload stay stable while ready is low, and ready never depends on valid.
interface shift_exec_if #(
  parameter int WIDTH = 16
);
  logic             InValid;
  logic             InReady;
  logic [3:0]       Opcode;
  logic [WIDTH-1:0] SrcData;
  logic [3:0]       Imm;
  logic [3:0]       DstReg;
  logic             Flush;
  logic [WIDTH-1:0] ShIn;
  logic [3:0]       ShVal;
  logic [1:0]       ShMode;
  logic [WIDTH-1:0] ShResult;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic [3:0]       OutDstReg;
  logic             IllegalOp;
  logic             ZFlag;
  logic             ZFlagWe;

  modport master (
    output InValid, Opcode, SrcData, Imm, DstReg, Flush, ShResult, OutReady,
    input  InReady, ShIn, ShVal, ShMode, OutValid, Result, OutDstReg,
           IllegalOp, ZFlag, ZFlagWe
  );

  modport slave (
    input  InValid, Opcode, SrcData, Imm, DstReg, Flush, ShResult, OutReady,
    output InReady, ShIn, ShVal, ShMode, OutValid, Result, OutDstReg,
           IllegalOp, ZFlag, ZFlagWe
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-entry execute stage for SLL/SRA/ROR: stage A drives the external shifter,
// stage B holds its result for writeback and maintains the Z flag.
module shift_exec_stage #(
  parameter int WIDTH    = 16,
  parameter bit ZFLAG_EN = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  shift_exec_if.slave bus
);

  if (WIDTH != 16) begin : g_bad_width
    $error("shift_exec_stage: WIDTH must be 16 to match the shifter");
  end

  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic             a_valid;
  logic             a_illegal;
  logic [3:0]       a_dst;
  logic             b_valid;
  logic             advance_a;
  logic             accept;
  logic             drain;
  logic [1:0]       dec_mode;
  logic             dec_legal;
  logic [WIDTH-1:0] zero_word;

  assign zero_word     = '0;
  assign advance_a     = a_valid & (~b_valid | bus.OutReady);
  assign bus.InReady   = ~bus.Flush & (~a_valid | advance_a);
  assign accept        = bus.InValid & bus.InReady;
  assign drain         = b_valid & bus.OutReady;
  assign bus.OutValid  = b_valid;

  // Illegal opcodes decode to a zero-distance SLL so the operand passes through untouched.
  always_comb begin
    dec_mode  = 2'd0;
    dec_legal = 1'b1;
    case (bus.Opcode)
      OP_SLL:  dec_mode = 2'd0;
      OP_SRA:  dec_mode = 2'd1;
      OP_ROR:  dec_mode = 2'd2;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid    <= 1'b0;
      a_illegal  <= 1'b0;
      a_dst      <= 4'd0;
      bus.ShIn   <= '0;
      bus.ShVal  <= 4'd0;
      bus.ShMode <= 2'd0;
    end else if (bus.Flush) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid    <= 1'b1;
      a_illegal  <= ~dec_legal;
      a_dst      <= bus.DstReg;
      bus.ShIn   <= bus.SrcData;
      bus.ShVal  <= dec_legal ? bus.Imm : 4'd0;
      bus.ShMode <= dec_mode;
    end else if (advance_a) begin
      a_valid <= 1'b0;
    end
  end

  // A refill of B takes priority over its drain so a full pipe keeps streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid       <= 1'b0;
      bus.Result    <= '0;
      bus.OutDstReg <= 4'd0;
      bus.IllegalOp <= 1'b0;
    end else if (bus.Flush) begin
      b_valid <= 1'b0;
    end else if (advance_a) begin
      b_valid       <= 1'b1;
      bus.Result    <= bus.ShResult;
      bus.OutDstReg <= a_dst;
      bus.IllegalOp <= a_illegal;
    end else if (drain) begin
      b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ZFlag   <= 1'b0;
      bus.ZFlagWe <= 1'b0;
    end else if (!bus.Flush && drain && !bus.IllegalOp && ZFLAG_EN) begin
      bus.ZFlag   <= (bus.Result == zero_word);
      bus.ZFlagWe <= 1'b1;
    end else begin
      bus.ZFlagWe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: external shifter model, driver tasks, a scoreboard
// queue filled at accept time and a monitor that drains it on every output transfer.
module tb_shift_exec_stage;

  logic clk;
  logic rst_n;

  shift_exec_if #(.WIDTH(16)) bus ();

  shift_exec_stage #(.WIDTH(16), .ZFLAG_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational shifter the stage drives.
  logic [31:0] ror_word;
  assign ror_word = {bus.ShIn, bus.ShIn} >> bus.ShVal;
  always_comb begin
    case (bus.ShMode)
      2'd0:    bus.ShResult = bus.ShIn << bus.ShVal;
      2'd1:    bus.ShResult = $signed(bus.ShIn) >>> bus.ShVal;
      2'd2:    bus.ShResult = ror_word[15:0];
      default: bus.ShResult = 16'hDEAD;
    endcase
  end

  int errors = 0;
  int checks = 0;

  logic [20:0] exp_q[$];   // {illegal, dst, result}
  logic        exp_z  = 1'b0;
  logic        exp_we = 1'b0;

  function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] src,
                                             input logic [3:0] imm);
    int s;
    int n;
    s = int'(src);
    n = int'(imm);
    case (op)
      4'b0100: return 16'((s * (1 << n)) % 65536);
      4'b0101: begin
        if (s >= 32768) s = s - 65536;
        return 16'(s >>> n);
      end
      4'b0110: return 16'(((s >> n) | (s << (16 - n))) % 65536);
      default: return src;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outvalid"}, 32'(bus.OutValid), 32'd0);
    check({tag, "_result"},   32'(bus.Result),   32'd0);
    check({tag, "_dst"},      32'(bus.OutDstReg), 32'd0);
    check({tag, "_illegal"},  32'(bus.IllegalOp), 32'd0);
    check({tag, "_zflag"},    32'(bus.ZFlag),    32'd0);
    check({tag, "_zflagwe"},  32'(bus.ZFlagWe),  32'd0);
    check({tag, "_shctl"},    32'({bus.ShIn, bus.ShVal, bus.ShMode}), 32'd0);
  endtask

  // Drive one op from posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] src, input logic [3:0] imm,
                       input logic [3:0] dst);
    logic rdy;
    int   waited;
    bus.InValid = 1'b1;
    bus.Opcode  = op;
    bus.SrcData = src;
    bus.Imm     = imm;
    bus.DstReg  = dst;
    waited = 0;
    rdy    = 1'b0;
    while (!rdy && waited < 60) begin
      @(negedge clk);
      rdy = bus.InReady;
      @(posedge clk);
      #1;
      waited++;
    end
    if (rdy) begin
      exp_q.push_back({(op < 4'd4 || op > 4'd6), dst, ref_result(op, src, imm)});
    end else begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: InReady stayed 0 for %0d cycles, required 1", waited);
    end
    bus.InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: Z-flag model and in-order result comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [20:0] e;
      check("zflag_we", 32'(bus.ZFlagWe), 32'(exp_we));
      check("zflag",    32'(bus.ZFlag),   32'(exp_z));
      exp_we = 1'b0;
      if (!bus.Flush && bus.OutValid && bus.OutReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result 0x%0h dst %0d with nothing expected",
                   bus.Result, bus.OutDstReg);
        end else begin
          e = exp_q.pop_front();
          check("result",  32'(bus.Result),    32'(e[15:0]));
          check("dst",     32'(bus.OutDstReg), 32'(e[19:16]));
          check("illegal", 32'(bus.IllegalOp), 32'(e[20]));
          if (!e[20]) begin
            exp_z  = (e[15:0] == 16'd0);
            exp_we = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] held_res;
    logic [3:0]  held_dst;
    logic        z_before;
    logic [3:0]  r_op;

    rst_n       = 1'b0;
    bus.InValid = 1'b0;
    bus.Opcode  = 4'd0;
    bus.SrcData = 16'd0;
    bus.Imm     = 4'd0;
    bus.DstReg  = 4'd0;
    bus.Flush   = 1'b0;
    bus.OutReady = 1'b1;
    idle(2);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Latency: accept edge N, output after edge N+1.
    issue(4'b0100, 16'h0001, 4'd15, 4'd1);
    @(negedge clk);
    check("latency_n", 32'(bus.OutValid), 32'd0);
    @(negedge clk);
    check("latency_n1", 32'(bus.OutValid), 32'd1);
    idle(2);

    // Back-to-back SRA then ROR.
    issue(4'b0101, 16'h8000, 4'd3, 4'd2);
    issue(4'b0110, 16'h0001, 4'd1, 4'd3);
    @(negedge clk);
    check("b2b_first", 32'(bus.OutValid), 32'd1);
    @(negedge clk);
    check("b2b_second", 32'(bus.OutValid), 32'd1);
    idle(2);

    // Zero result sets Z; illegal op leaves it alone.
    issue(4'b0100, 16'h00F0, 4'd12, 4'd4);
    issue(4'b0000, 16'h0000, 4'd7, 4'd5);
    idle(4);
    check("z_after_illegal", 32'(bus.ZFlag), 32'd1);

    // Back-pressure: two held, third stalls with stable outputs.
    bus.OutReady = 1'b0;
    issue(4'b0100, 16'h1234, 4'd4, 4'd6);
    issue(4'b0101, 16'h1234, 4'd4, 4'd7);
    fork
      issue(4'b0110, 16'h1234, 4'd4, 4'd8);
    join_none
    @(negedge clk);
    held_res = bus.Result;
    held_dst = bus.OutDstReg;
    check("stall_inready", 32'(bus.InReady), 32'd0);
    check("stall_outvalid", 32'(bus.OutValid), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("stall_inready_hold", 32'(bus.InReady), 32'd0);
      check("stall_result_hold", 32'(bus.Result), 32'(held_res));
      check("stall_dst_hold", 32'(bus.OutDstReg), 32'(held_dst));
    end
    @(posedge clk);
    #1;
    bus.OutReady = 1'b1;
    idle(8);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Flush with both slots full and a new op offered.
    bus.OutReady = 1'b0;
    issue(4'b0100, 16'h0F0F, 4'd1, 4'd9);
    issue(4'b0110, 16'hA5A5, 4'd3, 4'd10);
    bus.InValid = 1'b1;
    bus.Opcode  = 4'b0100;
    bus.SrcData = 16'h5555;
    bus.Imm     = 4'd2;
    bus.DstReg  = 4'd11;
    bus.Flush   = 1'b1;
    @(negedge clk);
    z_before = bus.ZFlag;
    check("flush_inready_low", 32'(bus.InReady), 32'd0);
    @(posedge clk);
    #1;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_outvalid", 32'(bus.OutValid), 32'd0);
    check("flush_inready", 32'(bus.InReady), 32'd1);
    check("flush_zflag", 32'(bus.ZFlag), 32'(z_before));
    @(posedge clk);
    #1;
    bus.OutReady = 1'b1;
    idle(4);

    // Randomized traffic with random back-pressure.
    fork
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge clk);
          #1;
          bus.OutReady = ($urandom_range(0, 3) != 0);
        end
        bus.OutReady = 1'b1;
      end
    join_none
    for (int i = 0; i < 80; i++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 6));
      issue(r_op, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait fork;
    idle(6);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges while ops are in flight.
    issue(4'b0100, 16'h0001, 4'd15, 4'd12);
    issue(4'b0101, 16'hF00F, 4'd2, 4'd13);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    exp_z  = 1'b0;
    exp_we = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'b0100, 16'h0003, 4'd1, 4'd14);
    idle(4);
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-entry pipelined execute stage for the shift instructions (SLL, SRA, ROR) of the 16-bit core.
- Sits between the ID/EX operand bus and writeback.
- Registers the operands and decodes the opcode into the shifter's Mode and ShiftVal controls. It drives the combinational shifter and registers the shifter's output into a result slot.
- Uses valid/ready handshakes on both sides and maintains the Z flag for shift instructions.

Parameters:
- WIDTH, 16, datapath width; fixed to 16 to match the shifter. Any other value is a configuration error.
- ZFLAG_EN, 1, when 1 a shift writes the Z flag on output transfer; when 0, ZFlagWe is tied to 0.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  upstream has a shift op.
- InReady  output  1  stage A can accept.
- Opcode  input  4  4'b0100 SLL, 4'b0101 SRA, 4'b0110 ROR; anything else is illegal.
- SrcData  input  16  value to shift.
- Imm  input  4  shift amount, 0..15.
- DstReg  input  4  destination register id.
- Flush  input  1  synchronous pipeline kill.
- ShIn  output  16  to the shifter's ShiftIn.
- ShVal  output  4  to the shifter's ShiftVal.
- ShMode  output  2  to the shifter's Mode: 0 SLL, 1 SRA, 2 ROR; never 3.
- ShResult  input  16  from the shifter's ShiftOut.
- OutValid  output  1  result slot holds data.
- OutReady  input  1  writeback accepts.
- Result  output  16  shifted value.
- OutDstReg  output  4  destination id.
- IllegalOp  output  1  result slot came from an illegal opcode.
- ZFlag  output  1  registered zero flag.
- ZFlagWe  output  1  pulses for one cycle when ZFlag was updated on the previous edge.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - AValid=0, BValid=0, OutValid=0.
  - Result=0, OutDstReg=0, IllegalOp=0, ZFlag=0, ZFlagWe=0.
  - ShIn=0, ShVal=0, ShMode=0.
  - In-flight ops are discarded. The first accept is possible in the first cycle after deassertion.
- Stage A (operand register):
  - AdvanceA = AValid & (~BValid | OutReady).
  - InReady = ~Flush & (~AValid | AdvanceA).
  - On InValid & InReady: latch SrcData, Imm, DstReg and the decoded mode; set AValid=1.
  - Legal opcodes: ShMode is 0/1/2 per the opcode and ShVal=Imm.
  - Illegal opcodes: ShMode=0, ShVal=0 (so the result is SrcData unchanged) and the A-illegal bit is set.
  - ShIn, ShVal and ShMode are registered outputs of stage A. The shifter path is purely combinational back into ShResult within the same cycle.
  - If AdvanceA occurs with no new accept, AValid goes to 0.
- Stage B (result register):
  - On AdvanceA, capture ShResult into Result, along with the A-stage DstReg and illegal bit; set BValid=1.
  - When OutValid & OutReady with no AdvanceA, BValid goes to 0. OutValid = BValid.
- Timing:
  - Latency: accept at edge N gives OutValid=1 after edge N+1 (2-cycle latency).
  - Throughput is 1 op/cycle with OutReady held high.
  - With OutReady=0, at most 2 ops are held. InReady drops when both slots are full.
  - Result, OutDstReg and IllegalOp are stable while OutValid & ~OutReady.
- Z flag:
  - On a transfer (OutValid & OutReady) with IllegalOp=0 and ZFLAG_EN=1: ZFlag <= (Result==0) and ZFlagWe <= 1.
  - Otherwise ZFlagWe <= 0 and ZFlag holds.
  - An illegal op never modifies ZFlag.
- Flush (synchronous):
  - At the next edge, AValid=0 and BValid=0.
  - No accept and no Z update occur in the Flush cycle.
  - Flush wins over every simultaneous event.
  - ZFlag keeps its prior value.
- Simultaneous accept and drain: when both slots are full and OutReady=1, B takes A while A takes the new op in the same edge. No bubble is inserted.
- Imm=0 passes SrcData unchanged for all three modes.

Test Plan:
- SLL SrcData=0x0001, Imm=15, OutReady=1 -> OutValid 2 cycles after accept, Result=0x8000, ZFlag=0, ZFlagWe pulses once.
- SRA 0x8000 by 3 -> 0xF000; then ROR 0x0001 by 1 -> 0x8000; issued back-to-back -> OutValid high on 2 consecutive cycles with the results in order.
- SLL 0x00F0 by 12 -> Result=0x0000 and ZFlag=1. Follow with opcode 4'b0000, SrcData=0 -> IllegalOp=1, Result=0x0000, ZFlag stays 1, ZFlagWe=0.
- OutReady=0, issue 3 ops (0x1234 SLL 4, 0x1234 SRA 4, 0x1234 ROR 4):
  - InReady=0 after 2 accepts; outputs are held stable.
  - Release OutReady -> 0x2340, 0x0123, 0x4123 in order, no loss or duplication.
- With both slots full, assert Flush together with InValid=1 -> next cycle OutValid=0 and InReady=1. The flushed ops never appear, and ZFlag is unchanged.
- Assert rst_n=0 mid-stream, asynchronously between edges -> all outputs 0 immediately. After release, a new SLL 0x0003 by 1 yields 0x0006.
